dbus_sram_responder: RTL and testbench
======================================

Name: dbus_sram_responder

Overview:
- Slave (responder) end of the core's data-bus protocol: accepts `dbus_req_t` from the memory stage and returns `dbus_resp_t`.
- Backed by an internal word-addressed SRAM array. Serves as simulation/FPGA data memory and as the reference responder for verifying the memory-stage request FSM.
- Handles one outstanding request at a time, with a configurable read/write completion latency.

Parameters:
- ADDR_WIDTH, 12, word-index width; the array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from the addr_ok handshake to data_ok; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- dreq  input  dbus_req_t (72: valid 1, addr 32, size 3, strobe 4, data 32)  request from the initiator.
- dresp  output  dbus_resp_t (34: addr_ok 1, data_ok 1, data 32)  response to the initiator.

Behaviour:
- States: IDLE, WAIT. Reset state is IDLE.
- Reset values: dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0. The array contents are not reset.
- Address decode: word index = dreq.addr[ADDR_WIDTH+1:2]. Higher bits are ignored, so addresses wrap modulo the array size. addr[1:0] and size are ignored.
- Alignment checks are the initiator's job. Reads always return the full aligned word, and the initiator does lane extraction.
- IDLE, dreq.valid=1:
  - dresp.addr_ok=1 combinationally in the same cycle.
  - At that clock edge the responder latches the word index and strobe.
  - If strobe!=0, it writes each byte lane i where strobe[i]=1 from dreq.data[8i+7:8i].
  - If strobe==0, it reads the word into the data register (read-before-write is irrelevant; single access).
  - Next state is WAIT, with counter = LATENCY-1.
- IDLE, dreq.valid=0: addr_ok=0 and the state is held.
- WAIT:
  - addr_ok=0 regardless of dreq.valid. The initiator keeps valid high while waiting, and this must not be taken as a new request.
  - The counter decrements each cycle.
  - In the cycle where the counter reaches 0, registered dresp.data_ok=1 for exactly one cycle. dresp.data carries the read word; for writes it carries the pre-write word.
  - Next state is IDLE.
- addr_ok and data_ok are never high in the same cycle. A new request can be accepted at the earliest in the cycle after data_ok.
- Throughput: one request per LATENCY+1 cycles.
- dresp.data holds its last value outside data_ok cycles.
- A write is committed at its handshake edge, so any later request sees the new data (read-after-write, including back-to-back).
- Reset mid-operation:
  - The state returns to IDLE, data_ok drops immediately, and the pending response is discarded.
  - A write whose handshake edge occurred before reset remains committed.
- The initiator may drop dreq.valid in WAIT (exception flush). The transaction still completes and data_ok is still pulsed. Requests are not cancellable once accepted.

Optional Feature:
- Macro DBUS_RANDOM_STALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR runs: taps 8,6,5,4; reset seed 8'hA5; advances every cycle.
  - In IDLE, addr_ok = dreq.valid && lfsr[0]. A stalled request stays pending until a cycle where lfsr[0]=1.
  - In WAIT, the counter decrements only when lfsr[1]=1, which stretches latency randomly.
  - All other rules hold, so this exercises the initiator's LOAD/LOADWAIT and STORE/STOREWAIT paths.
- When undefined: no LFSR is instantiated, and timing is exactly as in Behaviour.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with dreq.valid=1 -> addr_ok=0, data_ok=0, data=0 throughout; first addr_ok in the first cycle after release.
- Write then read: store addr=0x0000_0010, strobe=4'hF, data=0xDEADBEEF (LATENCY=1) -> addr_ok at T, data_ok at T+1. Then load 0x10 -> data_ok at T+3 with data=0xDEADBEEF.
- Byte strobe: word preset 0x11223344; store addr=0x10, strobe=4'b0100, data=0x00AA0000 -> a later read returns 0x11AA3344.
- Held valid in WAIT: LATENCY=3, valid kept high for 6 cycles -> exactly one addr_ok at T, one data_ok at T+3, next addr_ok at T+4.
- Wrap-around: ADDR_WIDTH=12, store 0x5A5A5A5A to addr 0x0000_4000 -> read of addr 0x0 returns 0x5A5A5A5A.
- Reset mid-WAIT: LATENCY=4, load accepted at T, resetn pulsed low at T+2 -> no data_ok; state IDLE; a new request is accepted immediately after release.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: responder end of the core data bus, backed by a
// word-addressed SRAM. One request is outstanding at a time, and each one
// completes LATENCY cycles after its addr_ok handshake.
//
// Handshake: addr_ok is combinational and is high only in IDLE while
// dreq.valid is high. The request is taken at the same rising edge.
// data_ok is a registered one-cycle pulse, and dresp.data is valid in that
// cycle. addr_ok and data_ok are never high together. A new request can be
// accepted at the earliest in the cycle after data_ok. Once a request is
// accepted it always completes, even if dreq.valid drops.
//
// Optional build macro: DBUS_RANDOM_STALL_EN adds an 8-bit LFSR. The LFSR
// randomly withholds addr_ok and randomly stretches the completion latency.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                  state;
  logic [3:0]              cnt;
  logic                    data_ok_q;
  logic [31:0]             data_q;
  logic [31:0]             pend_word;
  logic [31:0]             mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    accept;
  logic                    dec;
  logic                    unused_req_bits;

  // Word index: the byte offset and the high bits are dropped, so addresses
  // wrap modulo the array size. The size field is the initiator's concern.
  assign idx             = dreq.addr[ADDR_WIDTH+1:2];
  assign unused_req_bits = ^{dreq.addr[31:ADDR_WIDTH+2], dreq.addr[1:0], dreq.size};

`ifdef DBUS_RANDOM_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR with taps 8,6,5,4. It advances every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign accept = resetn && (state == IDLE) && dreq.valid && lfsr[0];
  assign dec    = lfsr[1];
`else
  // addr_ok is gated by resetn so that a request held during reset is not seen.
  assign accept = resetn && (state == IDLE) && dreq.valid;
  assign dec    = 1'b1;
`endif

  assign dresp.addr_ok = accept;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = data_q;

  // SRAM port: capture the old word, then write the strobed byte lanes.
  // This runs at the handshake edge, so later requests see the new data.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_word <= mem[idx];
      for (int i = 0; i < 4; i++) begin
        if (dreq.strobe[i]) mem[idx][8*i +: 8] <= dreq.data[8*i +: 8];
      end
    end
  end

  // Request FSM: counts down the latency and pulses data_ok once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      data_ok_q <= 1'b0;
      data_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          data_ok_q <= 1'b0;
          if (accept) begin
            state <= WAIT;
            cnt   <= LAT_M1;
            if (LAT_M1 == 4'd0) begin
              data_ok_q <= 1'b1;
              data_q    <= mem[idx];
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= IDLE;
            data_ok_q <= 1'b0;
          end else if (dec) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              data_ok_q <= 1'b1;
              data_q    <= pend_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder. There are three instances: LATENCY=1 is the
// main data path, LATENCY=3 covers held valid and flush, and LATENCY=4
// covers reset while a request is outstanding.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
  dbus_req_t  dreq1, dreq3, dreq4;
  dbus_resp_t resp1, resp3, resp4;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];
  logic [31:0] model[int];

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u1 (
    .clk(clk), .resetn(rst_a), .dreq(dreq1), .dresp(resp1));
  dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u3 (
    .clk(clk), .resetn(rst_a), .dreq(dreq3), .dresp(resp3));
  dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(4)) u4 (
    .clk(clk), .resetn(rst_b), .dreq(dreq4), .dresp(resp4));

  // Scoreboard for u1: each data_ok pops one expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    bit          c;
    if (resp1.data_ok === 1'b1) begin
      n_checks++;
      if (resp1.addr_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_overlap: addr_ok=%b with data_ok, required 0", resp1.addr_ok);
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: data_ok with empty expected queue at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        if (c) begin
          n_checks++;
          if (resp1.data !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %h, required %h", resp1.data, e);
          end
        end
      end
    end
  end

  // Records the expected response of an accepted u1 request and updates the model.
  task automatic push_expect(input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wdata);
    int          idx;
    logic [31:0] w;
    idx = int'(addr[13:2]);
    if (model.exists(idx)) begin
      exp_q.push_back(model[idx]);
      chk_q.push_back(1'b1);
    end else begin
      exp_q.push_back(32'h0);
      chk_q.push_back(1'b0);
    end
    if (strb != 4'h0) begin
      if (strb == 4'hF || model.exists(idx)) begin
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
        model[idx] = w;
      end else begin
        model.delete(idx);
      end
    end
  endtask

  // Waits (bounded) for data_ok on u1.
  task automatic wait_ok1(output int t_ok, output logic [31:0] rdata);
    bit got;
    got = 1'b0;
    t_ok = -1;
    rdata = 32'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp1.data_ok === 1'b1) begin
        got = 1'b1;
        t_ok = cyc;
        rdata = resp1.data;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL data_ok_timeout: no data_ok within 40 cycles");
    end
  endtask

  // One complete u1 transaction: request, handshake, then response.
  task automatic txn1(input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wdata, output int t_acc, output int t_ok,
                      output logic [31:0] rdata);
    bit acc;
    @(posedge clk); #1;
    dreq1.valid  = 1'b1;
    dreq1.addr   = addr;
    dreq1.size   = 3'd2;
    dreq1.strobe = strb;
    dreq1.data   = wdata;
    acc = 1'b0;
    t_acc = -1;
    t_ok = -1;
    rdata = 32'h0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (resp1.addr_ok === 1'b1) begin
        acc = 1'b1;
        t_acc = cyc;
      end
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: addr %h not accepted within 40 cycles", addr);
      dreq1.valid = 1'b0;
      return;
    end
    push_expect(addr, strb, wdata);
    @(posedge clk); #1;
    dreq1.valid = 1'b0;
    wait_ok1(t_ok, rdata);
  endtask

  task automatic test_reset();
    int          t;
    logic [31:0] rd;
    rst_a = 1'b0;
    rst_b = 1'b0;
    dreq1 = '0;
    dreq3 = '0;
    dreq4 = '0;
    dreq1.valid = 1'b1;
    dreq1.addr  = 32'h100;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({resp1.addr_ok, resp1.data_ok, resp1.data} !== 34'h0) begin
        n_fail++;
        $display("FAIL reset_u1: addr_ok=%b data_ok=%b data=%h, required all 0",
                 resp1.addr_ok, resp1.data_ok, resp1.data);
      end
      n_checks++;
      if ({resp4.addr_ok, resp4.data_ok, resp4.data} !== 34'h0) begin
        n_fail++;
        $display("FAIL reset_u4: addr_ok=%b data_ok=%b data=%h, required all 0",
                 resp4.addr_ok, resp4.data_ok, resp4.data);
      end
    end
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp1.addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_accept: addr_ok=%b, required 1", resp1.addr_ok);
    end else begin
      push_expect(32'h100, 4'h0, 32'h0);
    end
    @(posedge clk); #1;
    dreq1.valid = 1'b0;
    wait_ok1(t, rd);
  endtask

  task automatic test_write_read();
    int          ta, to, ta2, to2;
    logic [31:0] rd;
    txn1(32'h0000_0010, 4'hF, 32'hDEADBEEF, ta, to, rd);
    n_checks++;
    if (to != ta + 1) begin
      n_fail++;
      $display("FAIL store_latency: data_ok at T+%0d, required T+1", to - ta);
    end
    txn1(32'h0000_0010, 4'h0, 32'h0, ta2, to2, rd);
    n_checks++;
    if (to2 != ta + 3) begin
      n_fail++;
      $display("FAIL load_after_store: data_ok at T+%0d, required T+3", to2 - ta);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_data: got %h, required deadbeef", rd);
    end
  endtask

  task automatic test_byte_strobe();
    int          ta, to;
    logic [31:0] rd;
    txn1(32'h10, 4'hF, 32'h11223344, ta, to, rd);
    txn1(32'h10, 4'b0100, 32'h00AA0000, ta, to, rd);
    n_checks++;
    if (rd !== 32'h11223344) begin
      n_fail++;
      $display("FAIL strobe_prewrite: got %h, required 11223344", rd);
    end
    txn1(32'h10, 4'h0, 32'h0, ta, to, rd);
    n_checks++;
    if (rd !== 32'h11AA3344) begin
      n_fail++;
      $display("FAIL strobe_merge: got %h, required 11aa3344", rd);
    end
  endtask

  task automatic test_wrap();
    int          ta, to;
    logic [31:0] rd;
    txn1(32'h0000_4000, 4'hF, 32'h5A5A5A5A, ta, to, rd);
    txn1(32'h0000_0000, 4'h0, 32'h0, ta, to, rd);
    n_checks++;
    if (rd !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL wrap_read: got %h, required 5a5a5a5a", rd);
    end
  endtask

  task automatic test_back_to_back();
    int          ta, to, prev_ok;
    logic [31:0] rd, a;
    logic [3:0]  s;
    prev_ok = -1;
    for (int n = 0; n < 24; n++) begin
      a = {16'h0, 2'($urandom_range(0, 3)), 10'h0, 2'b00}
          | {25'h0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom_range(0, 3))};
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      txn1(a, s, $urandom, ta, to, rd);
      n_checks++;
      if (to != ta + 1) begin
        n_fail++;
        $display("FAIL b2b_latency: data_ok at T+%0d, required T+1", to - ta);
      end
      if (prev_ok >= 0) begin
        n_checks++;
        if (ta != prev_ok + 1) begin
          n_fail++;
          $display("FAIL b2b_throughput: accept %0d cycles after data_ok, required 1",
                   ta - prev_ok);
        end
      end
      prev_ok = to;
    end
  endtask

  task automatic test_held_valid();
    logic [5:0] ao, dk;
    @(posedge clk); #1;
    dreq3.valid  = 1'b1;
    dreq3.addr   = 32'h30;
    dreq3.size   = 3'd2;
    dreq3.strobe = 4'hF;
    dreq3.data   = 32'hCAFEF00D;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ao[k] = resp3.addr_ok;
      dk[k] = resp3.data_ok;
    end
    @(posedge clk); #1;
    dreq3.valid = 1'b0;
    n_checks++;
    if (ao !== 6'b010001) begin
      n_fail++;
      $display("FAIL held_addr_ok: pattern %b, required 010001", ao);
    end
    n_checks++;
    if (dk !== 6'b001000) begin
      n_fail++;
      $display("FAIL held_data_ok: pattern %b, required 001000", dk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_flush();
    logic [3:0]  dk;
    logic [31:0] d3;
    d3 = 32'h0;
    @(posedge clk); #1;
    dreq3.valid  = 1'b1;
    dreq3.addr   = 32'h30;
    dreq3.strobe = 4'h0;
    @(negedge clk);
    n_checks++;
    if (resp3.addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_accept: addr_ok=%b, required 1", resp3.addr_ok);
    end
    @(posedge clk); #1;
    dreq3.valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      dk[k-1] = resp3.data_ok;
      if (k == 3) d3 = resp3.data;
    end
    n_checks++;
    if (dk !== 4'b0100) begin
      n_fail++;
      $display("FAIL flush_data_ok: pattern %b, required 0100", dk);
    end
    n_checks++;
    if (d3 !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL flush_data: got %h, required cafef00d", d3);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] dk;
    logic [1:0] early;
    @(posedge clk); #1;
    dreq4.valid  = 1'b1;
    dreq4.addr   = 32'h40;
    dreq4.size   = 3'd2;
    dreq4.strobe = 4'h0;
    @(negedge clk);
    n_checks++;
    if (resp4.addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_accept: addr_ok=%b, required 1", resp4.addr_ok);
    end
    @(posedge clk); #1;
    dreq4.valid = 1'b0;
    @(negedge clk);
    early[0] = resp4.data_ok;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    early[1] = resp4.data_ok;
    @(posedge clk); #1;
    rst_b = 1'b1;
    dreq4.valid = 1'b1;
    dreq4.addr  = 32'h44;
    @(negedge clk);
    n_checks++;
    if (resp4.addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_accept_after_reset: addr_ok=%b, required 1", resp4.addr_ok);
    end
    @(posedge clk); #1;
    dreq4.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      dk[k] = resp4.data_ok;
    end
    n_checks++;
    if (early !== 2'b00) begin
      n_fail++;
      $display("FAIL rmw_early_data_ok: pattern %b, required 00", early);
    end
    n_checks++;
    if (dk !== 4'b1000) begin
      n_fail++;
      $display("FAIL rmw_data_ok: pattern %b, required 1000", dk);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_wrap();
    test_back_to_back();
    test_held_valid();
    test_flush();
    test_reset_mid_wait();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
